// File: rtl/vram_write_arbiter_pkg.sv
// Shared types and constants for the VRAM write arbiter.
// The blanking-only write window is enabled by the macro VRAM_ARB_BLANK_ONLY_EN.
package vga_pkg;

    localparam int ADDR_W   = 14;   // {vaddr[6:0], haddr[6:0]}
    localparam int COLOUR_W = 3;    // {red, green, blue}

    localparam logic [7:0] ABORT_CNT_MAX = 8'd255;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Requester and VRAM write-port signals of the VRAM write arbiter.
// master = requester/VRAM side, slave = arbiter.
interface vram_write_arbiter_if;
    import vga_pkg::*;

    logic                req0;
    logic [ADDR_W-1:0]   addr0;
    logic [COLOUR_W-1:0] data0;
    logic                gnt0;

    logic                req1;
    logic [ADDR_W-1:0]   addr1;
    logic [COLOUR_W-1:0] data1;
    logic                gnt1;

    logic                vram_we;
    logic [ADDR_W-1:0]   vram_waddr;
    logic [COLOUR_W-1:0] vram_wdata;

    modport master (
        output req0, addr0, data0,
        output req1, addr1, data1,
        input  gnt0, gnt1,
        input  vram_we, vram_waddr, vram_wdata
    );

    modport slave (
        input  req0, addr0, data0,
        input  req1, addr1, data1,
        output gnt0, gnt1,
        output vram_we, vram_waddr, vram_wdata
    );

endinterface

// File: rtl/vram_write_arbiter_rr.sv
// Two-way round-robin select for the VRAM write arbiter.
// The pointer remembers the last committed requester and moves only on commit,
// so an aborted write leaves the fairness order untouched.
module vram_arb_rr (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic commit,
    input  logic commit_idx,
    output logic winner
);

    logic last_gnt;

    // Pointer: reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= 1'b1;
        end else if (commit) begin
            last_gnt <= commit_idx;
        end
    end

    // Lone requester always wins; a tie goes to the one not granted last.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM write arbiter: two requesters share one VRAM write port.
// A request sampled in IDLE is latched and written in the following cycle.
// Macro VRAM_ARB_BLANK_ONLY_EN confines writes to blanking; a write whose
// cycle falls into active video is aborted and counted.
//
//  state | meaning
//  IDLE  | no write pending; arbitrate when the window is open
//  WRITE | latched write pending; commit if window still open, else abort
module vram_write_arbiter
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 haddr_enable,
    input  logic                 vaddr_enable,
    vram_write_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [7:0]           abort_cnt
);

    arb_state_t state;
    logic       win;
    logic       winner;
    logic       commit;
    logic       lat_idx;

`ifdef VRAM_ARB_BLANK_ONLY_EN
    // Writes allowed only while either sync controller reports blanking.
    always_comb begin
        win = ~(haddr_enable & vaddr_enable);
    end
`else
    logic blank_flags_unused;
    assign blank_flags_unused = haddr_enable ^ vaddr_enable;

    // Window permanently open; aborts cannot happen.
    always_comb begin
        win = 1'b1;
    end
`endif

    vram_arb_rr u_rr (
        .clk        (clk),
        .reset      (reset),
        .req0       (bus.req0),
        .req1       (bus.req1),
        .commit     (commit),
        .commit_idx (lat_idx),
        .winner     (winner)
    );

    // Strobe and grants are decided in the WRITE cycle itself, since the
    // window can close during it; address/data come from the latch.
    always_comb begin
        commit      = (state == WRITE) && win;
        bus.vram_we = commit;
        bus.gnt0    = commit && !lat_idx;
        bus.gnt1    = commit && lat_idx;
    end

    // Sequencer: latch the winner in IDLE, commit or abort in WRITE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            lat_idx        <= 1'b0;
            bus.vram_waddr <= '0;
            bus.vram_wdata <= '0;
            abort_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win && (bus.req0 || bus.req1)) begin
                        state          <= WRITE;
                        busy           <= 1'b1;
                        lat_idx        <= winner;
                        bus.vram_waddr <= winner ? bus.addr1 : bus.addr0;
                        bus.vram_wdata <= winner ? bus.data1 : bus.data0;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!win && (abort_cnt != ABORT_CNT_MAX)) begin
                        abort_cnt <= abort_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: a transaction-level model
// (one outstanding write, fairness pointer, abort tally) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vram_write_arbiter;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       h_en = 1'b0;
    logic       v_en = 1'b0;
    logic       busy;
    logic [7:0] abort_cnt;

    vram_write_arbiter_if bus ();

    vram_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .haddr_enable (h_en),
        .vaddr_enable (v_en),
        .bus          (bus),
        .busy         (busy),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit window_open();
`ifdef VRAM_ARB_BLANK_ONLY_EN
        return !(h_en && v_en);
`else
        return 1'b1;
`endif
    endfunction

    // Model: at most one accepted write outstanding; it lands next cycle if
    // the window is open, otherwise it is dropped and tallied.
    bit              m_pend = 1'b0;
    bit              m_idx = 1'b0;
    bit              m_last = 1'b1;
    logic [13:0]     m_addr = '0;
    logic [2:0]      m_data = '0;
    int              m_abort = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 1'b0; m_last = 1'b1; m_addr = '0; m_data = '0; m_abort = 0;
        end else if (m_pend) begin
            if (window_open()) m_last = m_idx;
            else if (m_abort < 255) m_abort++;
            m_pend = 1'b0;
        end else if (window_open() && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) m_idx = !m_last;
            else m_idx = bus.req1;
            m_addr = m_idx ? bus.addr1 : bus.addr0;
            m_data = m_idx ? bus.data1 : bus.data0;
            m_pend = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit e_we;
        e_we = m_pend && window_open();
        chk("vram_we",    32'(bus.vram_we),    32'(e_we));
        chk("gnt0",       32'(bus.gnt0),       32'(e_we && !m_idx));
        chk("gnt1",       32'(bus.gnt1),       32'(e_we && m_idx));
        chk("busy",       32'(busy),           32'(m_pend));
        chk("abort_cnt",  32'(abort_cnt),      32'(m_abort));
        chk("vram_waddr", 32'(bus.vram_waddr), 32'(m_addr));
        chk("vram_wdata", 32'(bus.vram_wdata), 32'(m_data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
        #1 reset = 1'b0;
        #11;
        chk("rst_we",    32'(bus.vram_we),    32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_waddr", 32'(bus.vram_waddr), 32'd0);
        chk("rst_abort", 32'(abort_cnt),      32'd0);
        step();
        reset = 1'b1;

        // Single write, one-cycle latency.
        bus.req0 = 1'b1; bus.addr0 = 14'h0123; bus.data0 = 3'b101;
        step(); mid();
        chk("t1_we",    32'(bus.vram_we),    32'd1);
        chk("t1_waddr", 32'(bus.vram_waddr), 32'h0123);
        chk("t1_wdata", 32'(bus.vram_wdata), 32'd5);
        chk("t1_gnt0",  32'(bus.gnt0),       32'd1);
        bus.req0 = 1'b0;
        step(); mid();
        chk("t1_we_off", 32'(bus.vram_we),    32'd0);
        chk("t1_hold",   32'(bus.vram_waddr), 32'h0123);

        // Continuous tie: alternate grants, one write per two cycles.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 14'h00AA; bus.data0 = 3'd1;
        bus.req1 = 1'b1; bus.addr1 = 14'h1555; bus.data1 = 3'd6;
        for (int k = 1; k <= 8; k++) begin
            step(); mid();
            chk("rr_gnt0", 32'(bus.gnt0), 32'(k == 1 || k == 5));
            chk("rr_gnt1", 32'(bus.gnt1), 32'(k == 3 || k == 7));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();

        // Lone requester 1 wins though it was granted last; drops after latch.
        bus.req1 = 1'b1; bus.addr1 = 14'h3FFF; bus.data1 = 3'd7;
        step();
        bus.req1 = 1'b0;
        mid();
        chk("drop_gnt1",  32'(bus.gnt1),       32'd1);
        chk("drop_waddr", 32'(bus.vram_waddr), 32'h3FFF);
        step();

        // Reset during WRITE discards the write; tie afterwards goes to 0.
        bus.req0 = 1'b1; bus.addr0 = 14'h0042; bus.data0 = 3'd2;
        step();
        #1 reset = 1'b0;
        #1;
        chk("rw_we",    32'(bus.vram_we),    32'd0);
        chk("rw_gnt0",  32'(bus.gnt0),       32'd0);
        chk("rw_busy",  32'(busy),           32'd0);
        chk("rw_waddr", 32'(bus.vram_waddr), 32'd0);
        bus.req0 = 1'b0;
        step();
        reset = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step(); mid();
        chk("rw_tie_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();

`ifdef VRAM_ARB_BLANK_ONLY_EN
        // Active video holds off the write until blanking starts.
        h_en = 1'b1; v_en = 1'b1;
        bus.req1 = 1'b1; bus.addr1 = 14'h0777; bus.data1 = 3'd2;
        for (int k = 0; k < 20; k++) begin
            step(); mid();
            chk("av_we", 32'(bus.vram_we), 32'd0);
        end
        h_en = 1'b0;
        step(); mid();
        chk("av_fire_we",   32'(bus.vram_we), 32'd1);
        chk("av_fire_gnt1", 32'(bus.gnt1),    32'd1);
        bus.req1 = 1'b0; v_en = 1'b0;
        step();

        // Abort in the WRITE cycle; pointer untouched.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 14'h0011; bus.data0 = 3'd3;
        step();
        h_en = 1'b1; v_en = 1'b1;
        mid();
        chk("ab_we",   32'(bus.vram_we), 32'd0);
        chk("ab_gnt0", 32'(bus.gnt0),    32'd0);
        step();
        chk("ab_cnt1", 32'(abort_cnt), 32'd1);
        h_en = 1'b0; v_en = 1'b0; bus.req1 = 1'b1;
        step(); mid();
        chk("ab_ptr_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        for (int k = 0; k < 300; k++) begin
            h_en = 1'b0; v_en = 1'b0; bus.req0 = 1'b1;
            step();
            h_en = 1'b1; v_en = 1'b1;
            step();
        end
        bus.req0 = 1'b0; h_en = 1'b0; v_en = 1'b0;
        mid();
        chk("ab_sat", 32'(abort_cnt), 32'd255);
        step();
`else
        // Enables ignored: write goes through in active video, no aborts.
        h_en = 1'b1; v_en = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 14'h2A2A; bus.data0 = 3'd4;
        step(); mid();
        chk("nb_gnt0",  32'(bus.gnt0),       32'd1);
        chk("nb_waddr", 32'(bus.vram_waddr), 32'h2A2A);
        bus.req0 = 1'b0;
        step(); mid();
        chk("nb_abort", 32'(abort_cnt), 32'd0);
        h_en = 1'b0; v_en = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, VRAM pixel address width, matching {vaddr[6:0], haddr[6:0]}.
REQ-002 Parameter COLOUR_W, 3, write data width as {red, green, blue}.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0  in  1  write request from requester 0; held high until gnt0.
REQ-006 addr0  in  ADDR_W  requester 0 pixel address; stable while req0 high.
REQ-007 data0  in  COLOUR_W  requester 0 pixel colour; stable while req0 high.
REQ-008 req1, addr1, data1  in  1/ADDR_W/COLOUR_W  requester 1, with the same rules as requester 0.
REQ-009 haddr_enable  in  1  horizontal active-video flag from the hsync controller.
REQ-010 vaddr_enable  in  1  vertical active-video flag from the vsync controller.
REQ-011 gnt0, gnt1  out  1  one-cycle pulse marking that requester's committed write.
REQ-012 vram_we  out  1  VRAM write strobe; one cycle per committed write.
REQ-013 vram_waddr  out  ADDR_W  VRAM write address; valid while vram_we is high.
REQ-014 vram_wdata  out  COLOUR_W  VRAM write colour; valid while vram_we is high.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 abort_cnt  out  8  saturating count of aborted writes.

Function
REQ-017 The FSM SHALL have two states, IDLE and WRITE.
REQ-018 Write window: win = ~(haddr_enable & vaddr_enable) when the macro is enabled; win = 1 otherwise.
REQ-019 Leaving IDLE: when win=1 and (req0|req1), select a winner, latch its addr/data, and go to WRITE on the next edge.
REQ-020 Staying in IDLE: when win=0 or no request is present, remain in IDLE and drive vram_we=0.
REQ-021 Arbitration SHALL be two-way round-robin: if both requests are high, grant the requester not granted last.
REQ-022 If only one request is high, that requester SHALL win regardless of the round-robin pointer.
REQ-023 The pointer SHALL change only on a committed write, never on an abort.
REQ-024 In WRITE with win=1, drive vram_we=1, the latched waddr/wdata, and the winner's gnt for exactly that cycle, then return to IDLE.
REQ-025 In WRITE with win=0 (active video began), suppress vram_we and gnt, increment abort_cnt (saturating at 255), and return to IDLE; the request is re-arbitrated later.
REQ-026 Latency SHALL be exactly one cycle from a request sampled in IDLE to vram_we/gnt.
REQ-027 Maximum throughput SHALL be one write per two cycles.
REQ-028 A request dropped after it was latched SHALL still commit, and its gnt SHALL still pulse.
REQ-029 gnt0 and gnt1 SHALL never be high together.
REQ-030 vram_we SHALL equal (gnt0 | gnt1) in every cycle.
REQ-031 vram_waddr and vram_wdata SHALL hold their last latched values when vram_we=0.

Reset
REQ-032 While reset=0, the block SHALL asynchronously force: state=IDLE, gnt0=gnt1=0, vram_we=0, vram_waddr=0, vram_wdata=0, busy=0, abort_cnt=0, and the pointer set so requester 0 wins the first tie.
REQ-033 Reset asserted during WRITE SHALL discard the latched write with no gnt and no abort count.
REQ-034 Reset release SHALL take effect on the first clk edge after reset=1.

Configuration
REQ-035 Macro VRAM_ARB_BLANK_ONLY_EN: defined, writes are confined to blanking (REQ-018) and abort logic is active.
REQ-036 Macro VRAM_ARB_BLANK_ONLY_EN undefined: win is constant 1, aborts never occur, and abort_cnt stays 0.

Structure
REQ-037 Package vga_pkg SHALL hold ADDR_W, COLOUR_W, the FSM state typedef {IDLE, WRITE}, and ABORT_CNT_MAX=255.
REQ-038 Sub-module vram_arb_rr SHALL hold the two-way round-robin select and pointer register; it takes req0, req1, and a commit strobe, and returns the winner index.

Verification
REQ-039 Release reset; at cycle 0 in blanking set req0=1, addr0=0x0123, data0=3'b101 -> cycle 1: vram_we=1, waddr=0x0123, wdata=101, gnt0=1; cycle 2: vram_we=0.
REQ-040 req0 and req1 held high continuously in blanking -> grants alternate gnt0, gnt1, gnt0, gnt1 on cycles 1, 3, 5, 7.
REQ-041 Macro defined, haddr_enable=vaddr_enable=1, req1=1 -> no vram_we for 20 cycles; it fires one cycle after haddr_enable falls.
REQ-042 Macro defined, request latched, then both enables rise in the WRITE cycle -> no vram_we or gnt, abort_cnt=1, pointer unchanged; 300 forced aborts -> abort_cnt=255.
REQ-043 reset pulsed low during WRITE -> all outputs 0 immediately; after release, the tie is won by requester 0.
REQ-044 Macro undefined, enables both high, req0=1 -> gnt0 on cycle 1 and abort_cnt stays 0.
